// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for elastic pipeline stages
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam logic [31:0] NOP_INSTR      = 32'd0;
    localparam int          DEFAULT_DATA_W = 64;
    localparam int          DEFAULT_STAT_W = 16;

    // Default bubble for a {PC, instruction} payload: PC zero, NOP instruction.
    localparam logic [63:0] DEFAULT_BUBBLE_64 = {32'd0, NOP_INSTR};

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter with async active-high reset
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic 2-entry (main + skid) pipeline register with registered in_ready
// Optional stall counter port stall_cnt is built only when PIPE_STATS_EN is defined.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                STAT_W     = DEFAULT_STAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef PIPE_STATS_EN
   ,output logic [STAT_W-1:0] stall_cnt
`endif
);

    if (DATA_W < 1 || STAT_W < 1) begin : g_param_check
        $error("pipe_stage_elastic: DATA_W and STAT_W must be >= 1");
    end

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              push, pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= BUBBLE_VAL;
            skid_q     <= BUBBLE_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Empty entries are always rewritten with BUBBLE_VAL so out_data needs no mux on out_valid.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = main_q;
        in_ready  = in_ready_q;
    end

`ifdef PIPE_STATS_EN
    pipe_sat_counter #(
        .W (STAT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );
`endif

endmodule
